// File: rtl/wordle_guess_ctrl.sv
// Wordle guess-entry sequencer: collects keyboard letters into a guess buffer,
// hands full guesses to the checker and counts attempts until a win or loss.
module wordle_guess_ctrl #(
  parameter int WORD_LEN  = 5,
  parameter int MAX_GUESS = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_ack,
  input  logic                  i_sel,
  input  logic                  i_del,
  input  logic                  i_enter,
  input  logic [7:0]            i_curr_letter,
  input  logic                  i_chk_done,
  input  logic                  i_chk_win,
  output logic [8*WORD_LEN-1:0] o_guess,
  output logic [2:0]            o_len,
  output logic [2:0]            o_attempt,
  output logic                  o_chk_req,
  output logic                  o_kbd_start,
  output logic                  o_win,
  output logic                  o_lose,
  output logic                  o_q_i,
  output logic                  o_q_entry,
  output logic                  o_q_check,
  output logic                  o_q_done
);

  typedef enum logic [3:0] {
    QI     = 4'b1000,
    QENTRY = 4'b0100,
    QCHECK = 4'b0010,
    QDONE  = 4'b0001
  } state_t;

  localparam logic [2:0] LEN_FULL     = 3'(WORD_LEN);
  localparam logic [2:0] LAST_ATTEMPT = 3'(MAX_GUESS);

  state_t                r_state, w_state_next;
  logic [8*WORD_LEN-1:0] r_guess, w_guess_next;
  logic [2:0]            r_len, w_len_next;
  logic [2:0]            r_attempt, w_attempt_next;
  logic                  r_kbd_start, w_kbd_start_next;
  logic                  r_win, w_win_next;
  logic                  r_lose, w_lose_next;
  logic                  w_is_letter;

  assign w_is_letter = (i_curr_letter >= 8'h41) && (i_curr_letter <= 8'h5A);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= QI;
      r_guess     <= '0;
      r_len       <= 3'd0;
      r_attempt   <= 3'd0;
      r_kbd_start <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_guess     <= w_guess_next;
      r_len       <= w_len_next;
      r_attempt   <= w_attempt_next;
      r_kbd_start <= w_kbd_start_next;
      r_win       <= w_win_next;
      r_lose      <= w_lose_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_guess_next     = r_guess;
    w_len_next       = r_len;
    w_attempt_next   = r_attempt;
    w_kbd_start_next = 1'b0;
    w_win_next       = r_win;
    w_lose_next      = r_lose;
    case (r_state)
      QI: begin
        if (i_start) begin
          w_state_next     = QENTRY;
          w_guess_next     = '0;
          w_len_next       = 3'd0;
          w_attempt_next   = 3'd0;
          w_win_next       = 1'b0;
          w_lose_next      = 1'b0;
          w_kbd_start_next = 1'b1;
        end
      end
      QENTRY: begin
        // Strict pulse priority: an asserted Enter blocks Del/Sel even when refused.
        if (i_enter) begin
          if (r_len == LEN_FULL) w_state_next = QCHECK;
        end else if (i_del) begin
          if (r_len != 3'd0) begin
            w_len_next = r_len - 3'd1;
            for (int i = 0; i < WORD_LEN; i++) begin
              if (3'(i) == r_len - 3'd1) w_guess_next[8*(WORD_LEN-1-i) +: 8] = 8'h00;
            end
          end
        end else if (i_sel) begin
          if ((r_len < LEN_FULL) && w_is_letter) begin
            w_len_next = r_len + 3'd1;
            for (int i = 0; i < WORD_LEN; i++) begin
              if (3'(i) == r_len) w_guess_next[8*(WORD_LEN-1-i) +: 8] = i_curr_letter;
            end
          end
        end
      end
      QCHECK: begin
        if (i_chk_done) begin
          w_attempt_next = r_attempt + 3'd1;
          if (i_chk_win) begin
            w_state_next = QDONE;
            w_win_next   = 1'b1;
          end else if (r_attempt + 3'd1 == LAST_ATTEMPT) begin
            w_state_next = QDONE;
            w_lose_next  = 1'b1;
          end else begin
            w_state_next = QENTRY;
            w_guess_next = '0;
            w_len_next   = 3'd0;
          end
        end
      end
      QDONE: begin
        if (i_ack) w_state_next = QI;
      end
      default: w_state_next = QI;
    endcase
  end

  assign o_guess     = r_guess;
  assign o_len       = r_len;
  assign o_attempt   = r_attempt;
  assign o_kbd_start = r_kbd_start;
  assign o_win       = r_win;
  assign o_lose      = r_lose;
  // Request and one-hot flags come straight off the state flops, so reset drops them at once.
  assign o_chk_req   = r_state[1];
  assign o_q_i       = r_state[3];
  assign o_q_entry   = r_state[2];
  assign o_q_check   = r_state[1];
  assign o_q_done    = r_state[0];

endmodule

// File: doc/wordle_guess_ctrl.md
# wordle_guess_ctrl

Guess-entry sequencer for the Wordle game. Sits between the on-screen keyboard cursor block and the guess checker. It collects letters chosen on the keyboard into a WORD_LEN-letter guess buffer and handles delete and enter. It then hands the completed guess to the checker and counts attempts until a win or until MAX_GUESS attempts are used up.

## Interface
- WORD_LEN, 5, letters per guess (2..7)
- MAX_GUESS, 6, attempts per game (1..7)
- Clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Start  in  1  level; begins a game from QI
- Ack  in  1  level; returns from QDONE to QI
- Sel  in  1  one-cycle pulse; append curr_letter
- Del  in  1  one-cycle pulse; remove last letter
- Enter  in  1  one-cycle pulse; submit guess
- curr_letter  in  8  ASCII letter under the keyboard cursor
- chk_done  in  1  one-cycle pulse from checker; result valid
- chk_win  in  1  checker verdict, sampled only with chk_done
- guess  out  8*WORD_LEN  guess buffer; position 0 at MSB byte, empty position = 8'h00
- len  out  3  letters currently in buffer
- attempt  out  3  number of completed (checked) guesses
- chk_req  out  1  level; high for the whole of QCHECK
- kbd_start  out  1  one-cycle pulse on the QI->QENTRY transition, starts the keyboard block
- win, lose  out  1  game result, valid in QDONE
- q_I, q_Entry, q_Check, q_Done  out  1  one-hot state

## Operation
- States, one-hot: QI=1000, QENTRY=0100, QCHECK=0010, QDONE=0001. Any illegal encoding goes to QI on the next edge.
- Reset values: state QI. guess, len, attempt, chk_req, kbd_start, win and lose are all 0.
- QI: Start=1 -> QENTRY. On that same edge:
  - clear guess, len, attempt, win and lose;
  - pulse kbd_start.
- QENTRY: at most one action per cycle. Priority is Enter > Del > Sel.
  - Enter with len==WORD_LEN -> QCHECK. Enter with len<WORD_LEN is ignored.
  - Del with len>0: len-1, and that position is written to 8'h00. Del with len==0 is ignored.
  - Sel with len<WORD_LEN and curr_letter in 'A'..'Z' (8'h41..8'h5A): curr_letter is written to position len, then len+1.
  - Sel when the buffer is full, or with a non-letter (',' or '.'), is ignored.
- QCHECK:
  - chk_req=1 and guess is held stable; Sel/Del/Enter are ignored.
  - On chk_done, attempt increments by 1, then:
    - chk_win=1 -> QDONE with win=1;
    - attempt+1==MAX_GUESS -> QDONE with lose=1;
    - otherwise -> QENTRY, and guess and len are cleared.
- QDONE: win, lose and guess are held. Ack=1 -> QI. win and lose stay valid until the next Start.
- Start in any state other than QI, and Ack in any state other than QDONE, are ignored.
- Arithmetic: len and attempt are 3-bit unsigned and never wrap; the guards above keep len ≤ WORD_LEN and attempt ≤ MAX_GUESS.

## Timing
- All outputs are registered and change only on the rising edge of Clk, apart from the asynchronous reset.
- Sel, Del or Enter sampled at edge n: guess and len are updated after edge n.
- Enter accepted at edge n: chk_req=1 from edge n until the edge that samples chk_done.
  - chk_req=0 in the first cycle after that edge.
  - Minimum QCHECK residency is 1 cycle; chk_done arriving in the first QCHECK cycle is accepted.
- chk_done outside QCHECK is ignored.
- Result path: win or lose is set on the same edge that enters QDONE.
- kbd_start is high for exactly the one cycle after the Start edge.
- reset asserted mid-game, including during QCHECK: all state is cleared immediately and chk_req drops asynchronously. The checker must tolerate an abandoned request.

## Test plan
- Reset, Start, then Sel with 'C','R','A','N','E' -> guess=0x4352414E45, len=5, state stays QENTRY. A 6th Sel 'S' -> no change.
- Sel 'A', Sel ',', Del, Del, Del -> after the ',' Sel, len=1 and guess=0x4100000000. Buffer ends empty with len=0; the extra Dels are ignored.
- Enter with len=4 -> stays QENTRY. Sel 'E' then Enter -> chk_req=1 next cycle. chk_done with chk_win=0 -> QENTRY, attempt=1, len=0, guess=0.
- Six full guesses, each answered with chk_win=0 -> after the 6th chk_done: QDONE, lose=1, win=0, attempt=6. Ack -> QI.
- Enter, Del and Sel asserted in the same cycle with a full buffer -> Enter wins, QCHECK. chk_done in the first QCHECK cycle with chk_win=1 -> QDONE, win=1, attempt=1.
- reset pulsed while chk_req=1 -> chk_req=0 immediately, state QI, all outputs 0. A subsequent Start produces kbd_start for one cycle.
